agmv_fetch_unit: RTL and testbench
==================================

Name: agmv_fetch_unit

Overview:
Parametrised instruction fetch unit for the AGM-V processor. It replaces the fixed PC/MAR/IR path that handled 8-bit, 3-byte instructions (opcode, operand1, operand2). It reads FIELDS consecutive memory words over a req/ack bus and assembles them into one instruction word. It hands the word to the decoder over a valid/ready handshake, and supports PC load (jump) with flush and memory wait states.

Parameters:
DATA_W, 8, width of one memory word / instruction field
ADDR_W, 8, program address width; PC and MAR wrap modulo 2^ADDR_W
FIELDS, 3, words per instruction (field 0 = opcode); legal range 1..8
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-low
fetch_en  in  1  1 = fetching allowed; 0 = no new instruction fetch started
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  read address (MAR)
mem_ack  in  1  read data valid this cycle
mem_rdata  in  DATA_W  read data, sampled when mem_req & mem_ack
pc_load  in  1  jump request
pc_load_addr  in  ADDR_W  jump target
ir_valid  out  1  ir_word/ir_pc hold a complete instruction
ir_ready  in  1  decoder accepts the instruction
ir_word  out  FIELDS*DATA_W  instruction; field 0 (opcode) in the MSBs
ir_pc  out  ADDR_W  address of field 0 of ir_word
busy  out  1  fetch in progress (state FETCH)

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state IDLE, PC=RESET_PC, MAR=RESET_PC, field count=0
  - mem_req=0, ir_valid=0, ir_word=0, ir_pc=0, busy=0
- FSM states: IDLE, FETCH, HOLD.
- IDLE → FETCH when fetch_en=1. MAR=PC and field count=0 are set on entry.
- FETCH:
  - mem_req=1 and busy=1.
  - mem_addr=MAR stays stable until mem_ack.
  - Zero-wait ack (ack in the first req cycle) is legal.
  - Each accepted ack stores mem_rdata into field[count], increments count and increments MAR (wraps).
- On the FIELDS-th ack:
  - ir_word and ir_pc=PC load.
  - ir_valid=1 from the next cycle.
  - PC <= PC+FIELDS (mod 2^ADDR_W).
  - Go to HOLD.
- HOLD:
  - mem_req=0; ir_valid=1; ir_word/ir_pc stable.
  - On ir_valid & ir_ready: ir_valid=0 next cycle; go to FETCH if fetch_en=1, else IDLE.
- mem_ack while mem_req=0 is ignored.
- Latency with zero-wait memory: FIELDS req cycles, then ir_valid. Throughput is 1 instruction per FIELDS+1 cycles.
- fetch_en deassert during FETCH: the current instruction still completes.
- pc_load (priority over all but reset), next state:
  - PC=MAR=pc_load_addr, count=0, ir_valid=0.
  - State FETCH if fetch_en, else IDLE.
  - An ack in the same cycle is discarded.
  - A transfer (ir_valid&ir_ready) in the same cycle counts as consumed.
- Wrap-around: an instruction may straddle address 2^ADDR_W-1 → 0. ir_pc is the field-0 address.
- Reset mid-fetch abandons partial fields. There is no bus cleanup; the memory must tolerate a dropped req.

Optional Feature:
Macro AGMV_FETCH_PREFETCH_EN.
- Defined:
  - A 2-entry instruction queue sits between the assembler and the ir_* outputs.
  - Fetching continues while the queue is not full, so HOLD is entered only when both entries are full.
  - ir_valid = queue not empty; ir_word/ir_pc come from the head.
  - Simultaneous push and pop is allowed when full.
  - pc_load flushes both entries and the partial fetch.
  - Zero-wait throughput becomes 1 instruction per FIELDS cycles.
- Undefined: single IR register, exactly as described above.

Decomposition:
- Package agmv_pkg holds:
  - the fetch state enum (IDLE/FETCH/HOLD)
  - the default DATA_W/ADDR_W/FIELDS constants
  - a function giving the bit slice of field k in ir_word
- One sub-module, agmv_fetch_queue: 2-entry FIFO with push/pop/flush, instantiated only under AGMV_FETCH_PREFETCH_EN.

Test Plan:
- Basic fetch:
  - Stimulus: default params, zero-wait memory, RAM[0..5]=01,00,02,01,01,02, fetch_en=1, ir_ready=1.
  - Response: ir_word=0x010002 with ir_pc=0x00, then 0x010102 with ir_pc=0x03. First ir_valid appears 4 cycles after the first mem_req.
- Wait states:
  - Stimulus: ack delayed 2 cycles per word.
  - Response: mem_addr stays stable during each wait; same ir_word values; first ir_valid appears 10 cycles after the first req.
- Backpressure:
  - Stimulus: hold ir_ready=0 for 5 cycles.
  - Response: ir_valid stays high and ir_word is unchanged. mem_req=0 throughout (prefetch off); with prefetch on, mem_req stops after 2 instructions are queued.
- Jump mid-fetch:
  - Stimulus: pc_load=1, pc_load_addr=0x10 on the cycle of the 2nd ack.
  - Response: that ack is discarded; next mem_addr=0x10; ir_pc=0x10; no instruction from address 0x00 is delivered.
- Wrap-around:
  - Stimulus: pc_load_addr=0xFE.
  - Response: mem_addr sequence FE, FF, 00; ir_pc=0xFE; next fetch starts at 0x01.
- Async reset mid-fetch:
  - Stimulus: rst=0 between clock edges.
  - Response: mem_req, ir_valid and busy go to 0 immediately. After release, the first mem_addr is RESET_PC.

Source files
------------

// File: rtl/agmv_pkg.sv
// Shared types and constants for the AGM-V fetch path.
package agmv_pkg;

    localparam int AGMV_DATA_W = 8;
    localparam int AGMV_ADDR_W = 8;
    localparam int AGMV_FIELDS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // LSB position of field k inside an instruction word; field 0 sits in the MSBs
    function automatic int field_lsb(input int k, input int fields, input int data_w);
        return (fields - 1 - k) * data_w;
    endfunction

endpackage

// File: rtl/agmv_fetch_queue.sv
// Two-entry instruction FIFO between the fetch assembler and the decoder.
// Push and pop in the same cycle are allowed even when full; flush empties it.
module agmv_fetch_queue #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [1:0][W-1:0] ent;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign rdata   = ent[rd_ptr];

    // Storage, pointers and occupancy; flush drops everything but keeps stale data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                ent[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/agmv_fetch_unit.sv
// AGM-V instruction fetch unit: reads FIELDS consecutive words over a req/ack
// bus, assembles them (field 0 in the MSBs) and offers the instruction to the
// decoder over valid/ready. Supports jumps (pc_load) with flush and wait states.
// Optional macro AGMV_FETCH_PREFETCH_EN adds a 2-entry instruction queue so
// fetching continues while the decoder still holds earlier instructions.
module agmv_fetch_unit
    import agmv_pkg::*;
#(
    parameter int                DATA_W   = AGMV_DATA_W,
    parameter int                ADDR_W   = AGMV_ADDR_W,
    parameter int                FIELDS   = AGMV_FIELDS,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic                     mem_req,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_ack,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     pc_load,
    input  logic [ADDR_W-1:0]        pc_load_addr,
    output logic                     ir_valid,
    input  logic                     ir_ready,
    output logic [FIELDS*DATA_W-1:0] ir_word,
    output logic [ADDR_W-1:0]        ir_pc,
    output logic                     busy
);

    localparam int IW    = FIELDS * DATA_W;
    localparam int CNT_W = (FIELDS > 1) ? $clog2(FIELDS) : 1;

    fetch_state_e                  state;
    logic [ADDR_W-1:0]             pc;
    logic [ADDR_W-1:0]             mar;
    logic [CNT_W-1:0]              cnt;
    logic [FIELDS-1:0][DATA_W-1:0] fld_q;
    logic [FIELDS-1:0][DATA_W-1:0] fld_nxt;
    logic [IW-1:0]                 asm_word;
    logic                          last_field;
    logic                          done;
    logic                          xfer;
    logic                          q_full;
    logic                          full_after;

    assign mem_addr   = mar;
    assign last_field = (cnt == CNT_W'(FIELDS - 1));
    // A completed instruction; a jump in the same cycle throws the last word away
    assign done       = (state == FETCH) && mem_req && mem_ack && last_field && !pc_load;
    assign xfer       = ir_valid && ir_ready;

    // Field buffer with the word arriving this cycle merged in at the current slot
    always_comb begin
        fld_nxt      = fld_q;
        fld_nxt[cnt] = mem_rdata;
    end

    for (genvar k = 0; k < FIELDS; k++) begin : g_fld
        assign asm_word[field_lsb(k, FIELDS, DATA_W) +: DATA_W] = fld_nxt[k];
    end

    // Fetch sequencer: IDLE/FETCH/HOLD with registered mem_req and busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            mar     <= RESET_PC;
            cnt     <= '0;
            fld_q   <= '0;
            mem_req <= 1'b0;
            busy    <= 1'b0;
        end else if (pc_load) begin
            pc      <= pc_load_addr;
            mar     <= pc_load_addr;
            cnt     <= '0;
            state   <= fetch_en ? FETCH : IDLE;
            mem_req <= fetch_en;
            busy    <= fetch_en;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en && !q_full) begin
                        state   <= FETCH;
                        mar     <= pc;
                        cnt     <= '0;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_req && mem_ack) begin
                        fld_q <= fld_nxt;
                        mar   <= mar + ADDR_W'(1);
                        if (last_field) begin
                            cnt <= '0;
                            pc  <= pc + ADDR_W'(FIELDS);
                            if (full_after) begin
                                state   <= HOLD;
                                mem_req <= 1'b0;
                                busy    <= 1'b0;
                            end else if (!fetch_en) begin
                                state   <= IDLE;
                                mem_req <= 1'b0;
                                busy    <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        state   <= fetch_en ? FETCH : IDLE;
                        mar     <= pc;
                        cnt     <= '0;
                        mem_req <= fetch_en;
                        busy    <= fetch_en;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef AGMV_FETCH_PREFETCH_EN
    logic [1:0]           q_count;
    logic [IW+ADDR_W-1:0] q_head;

    agmv_fetch_queue #(
        .W(IW + ADDR_W)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (pc_load),
        .push  (done),
        .pop   (xfer),
        .wdata ({asm_word, pc}),
        .rdata (q_head),
        .count (q_count)
    );

    assign ir_valid   = (q_count != 2'd0);
    assign {ir_word, ir_pc} = q_head;
    assign q_full     = (q_count == 2'd2);
    // Queue is full after this cycle's push unless the decoder pops at the same time
    assign full_after = (q_count == 2'd2) || ((q_count == 2'd1) && !xfer);
`else
    // Only one instruction register, so every completion parks in HOLD
    assign q_full     = ir_valid;
    assign full_after = 1'b1;

    // Instruction register: load on completion, clear on hand-off or jump
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_valid <= 1'b0;
            ir_word  <= '0;
            ir_pc    <= '0;
        end else if (pc_load) begin
            ir_valid <= 1'b0;
        end else if (done) begin
            ir_valid <= 1'b1;
            ir_word  <= asm_word;
            ir_pc    <= pc;
        end else if (xfer) begin
            ir_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_agmv_fetch_unit.sv
// Bench for agmv_fetch_unit (default parameters). A memory responder and a
// scoreboard run once per cycle: delivered instructions must be consecutive
// FIELDS-word groups of the memory image starting at the last jump target,
// and bus addresses must advance by one per accepted ack.
module tb_agmv_fetch_unit;

    localparam int FLD = 3;
`ifdef AGMV_FETCH_PREFETCH_EN
    localparam int THRU = FLD;
`else
    localparam int THRU = FLD + 1;
`endif

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        pc_load;
    logic [7:0]  pc_load_addr;
    logic        ir_valid;
    logic        ir_ready;
    logic [23:0] ir_word;
    logic [7:0]  ir_pc;
    logic        busy;

    agmv_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .pc_load      (pc_load),
        .pc_load_addr (pc_load_addr),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .ir_word      (ir_word),
        .ir_pc        (ir_pc),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  mem [256];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          wait_cfg = 0;
    bit          rand_mode = 0;
    int          rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
    bit          ld_req = 0;
    logic [7:0]  ld_addr = '0;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_pc;
    int          wcnt;
    int          first_req;
    int          first_vld;
    int          dlv_cyc [$];
    logic [7:0]  dlv_pc [$];
    logic [23:0] dlv_word [$];
    logic [7:0]  acc_addr [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    function automatic logic [23:0] mem_word(input logic [7:0] a);
        logic [23:0] w;
        w = '0;
        for (int k = 0; k < FLD; k++) w = {w[15:0], mem[8'(a + k)]};
        return w;
    endfunction

    // One clock: drive inputs for the coming edge, score what that edge will do
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_req) begin
            if (rand_mode) mem_ack = ($urandom_range(0, 2) == 0);
            else           mem_ack = (wcnt == wait_cfg);
            wcnt      = mem_ack ? 0 : wcnt + 1;
            mem_rdata = mem_ack ? mem[mem_addr] : 8'($urandom);
        end else begin
            wcnt      = 0;
            mem_ack   = rand_mode ? 1'($urandom) : 1'b0;
            mem_rdata = 8'($urandom);
        end
        ir_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom);
        if (rand_mode) begin
            ld_req   = ($urandom_range(0, 31) == 0);
            ld_addr  = 8'($urandom);
            fetch_en = ($urandom_range(0, 7) != 0);
        end
        pc_load      = ld_req;
        pc_load_addr = ld_addr;
        ld_req       = 1'b0;
        if (rst) begin
            if (mem_req && first_req < 0) first_req = cyc;
            if (ir_valid && first_vld < 0) first_vld = cyc;
            chk("busy_vs_req", busy, mem_req);
            if (mem_req) chk("mem_addr", mem_addr, exp_addr);
            if (ir_valid && ir_ready) begin
                chk("ir_pc", ir_pc, exp_pc);
                chk("ir_word", ir_word, mem_word(exp_pc));
                dlv_cyc.push_back(cyc);
                dlv_pc.push_back(ir_pc);
                dlv_word.push_back(ir_word);
                exp_pc = 8'(exp_pc + FLD);
            end
            if (pc_load) begin
                exp_addr = pc_load_addr;
                exp_pc   = pc_load_addr;
            end else if (mem_req && mem_ack) begin
                acc_addr.push_back(mem_addr);
                exp_addr = exp_addr + 8'd1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        exp_addr  = 8'h00;
        exp_pc    = 8'h00;
        wcnt      = 0;
        first_req = -1;
        first_vld = -1;
        dlv_cyc.delete();
        dlv_pc.delete();
        dlv_word.delete();
        acc_addr.delete();
        rst = 1'b1;
    endtask

    task automatic run_until_dlv(input int n, input int budget);
        int b;
        b = 0;
        while (dlv_pc.size() < n && b < budget) begin
            step();
            b++;
        end
        chk("deliveries_in_budget", 64'(dlv_pc.size() >= n), 64'd1);
    endtask

    initial begin
        rst = 1'b0; fetch_en = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        pc_load = 1'b0; pc_load_addr = '0; ir_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h02;
        mem[3] = 8'h01; mem[4] = 8'h01; mem[5] = 8'h02;

        // Reset values
        do_reset();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_ir_valid", ir_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ir_word", ir_word, 24'h0);
        chk("rst_ir_pc", ir_pc, 8'h0);

        // Basic zero-wait fetch
        run_until_dlv(2, 40);
        if (dlv_pc.size() >= 2) begin
            chk("basic_word0", dlv_word[0], 24'h010002);
            chk("basic_pc0", dlv_pc[0], 8'h00);
            chk("basic_word1", dlv_word[1], 24'h010102);
            chk("basic_pc1", dlv_pc[1], 8'h03);
            chk("basic_throughput", dlv_cyc[1] - dlv_cyc[0], THRU);
        end
        chk("basic_latency", first_vld - first_req + 1, 4);

        // Two wait states per word
        wait_cfg = 2;
        do_reset();
        run_until_dlv(2, 80);
        chk("wait_latency", first_vld - first_req + 1, 10);
        if (dlv_pc.size() >= 2) begin
            chk("wait_word0", dlv_word[0], 24'h010002);
            chk("wait_word1", dlv_word[1], 24'h010102);
        end
        wait_cfg = 0;

        // Backpressure
        rdy_mode = 1;
        do_reset();
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", ir_valid, 1'b1);
            chk("bp_word", ir_word, 24'h010002);
            chk("bp_pc", ir_pc, 8'h00);
            chk("bp_no_req", mem_req, 1'b0);
        end
        rdy_mode = 0;
        run_until_dlv(3, 40);

        // Jump on the cycle of the second ack
        do_reset();
        begin
            int b;
            b = 0;
            while (first_req < 0 && b < 20) begin step(); b++; end
        end
        ld_req = 1'b1; ld_addr = 8'h10;
        step();
        chk("jump_ack_seen", mem_ack, 1'b1);
        step();
        chk("jump_addr", mem_addr, 8'h10);
        run_until_dlv(1, 40);
        if (dlv_pc.size() >= 1) begin
            chk("jump_pc", dlv_pc[0], 8'h10);
            chk("jump_word", dlv_word[0], mem_word(8'h10));
        end

        // Wrap-around across 0xFF -> 0x00
        do_reset();
        ld_req = 1'b1; ld_addr = 8'hFE;
        run_until_dlv(2, 40);
        if (acc_addr.size() >= 3) begin
            chk("wrap_a0", acc_addr[0], 8'hFE);
            chk("wrap_a1", acc_addr[1], 8'hFF);
            chk("wrap_a2", acc_addr[2], 8'h00);
        end
        if (dlv_pc.size() >= 2) begin
            chk("wrap_pc0", dlv_pc[0], 8'hFE);
            chk("wrap_pc1", dlv_pc[1], 8'h01);
        end

        // Asynchronous reset in the middle of a fetch
        wait_cfg = 2;
        do_reset();
        begin
            int b;
            b = 0;
            while (first_req < 0 && b < 20) begin step(); b++; end
        end
        step();
        chk("pre_areset_busy", busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("areset_mem_req", mem_req, 1'b0);
        chk("areset_busy", busy, 1'b0);
        chk("areset_ir_valid", ir_valid, 1'b0);
        do_reset();
        begin
            int b;
            b = 0;
            while (first_req < 0 && b < 20) begin step(); b++; end
        end
        chk("areset_first_addr", mem_addr, 8'h00);
        wait_cfg = 0;

        // Random traffic: random acks, ready, jumps and fetch_en
        do_reset();
        rdy_mode  = 2;
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) step();
        chk("rand_progress", 64'(dlv_pc.size() > 50), 64'd1);
        rand_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
